// File: rtl/midi_tone_synth.sv
// MIDI note-event tone synthesiser: semitone half-period table plus octave shift,
// square-wave tone generator and velocity-driven PWM on the tone's high phase.
module midi_tone_synth #(
  parameter int CLK_FRE = 50_000_000,
  parameter int HP_W    = 22
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       note_valid,
  input  logic [7:0] note,
  input  logic [7:0] velocity,
  output logic       note_ready,
  output logic       active,
  output logic       tone_out,
  output logic       pwm_out
);

  typedef enum logic [1:0] {IDLE, DECODE, LOAD, PLAY} state_t;

  // Half period of semitone s in octave -1 (MIDI note s), rounded to whole cycles.
  function automatic logic [HP_W-1:0] hp_calc(input int s);
    real f;
    f = 8.17580;
    for (int i = 0; i < s; i++) f = f * 1.0594630943592953;
    return HP_W'($rtoi(real'(CLK_FRE) / (2.0 * f) + 0.5));
  endfunction

  localparam logic [HP_W-1:0] HP [12] = '{
    hp_calc(0), hp_calc(1), hp_calc(2),  hp_calc(3),
    hp_calc(4), hp_calc(5), hp_calc(6),  hp_calc(7),
    hp_calc(8), hp_calc(9), hp_calc(10), hp_calc(11)
  };

  state_t          state, state_next;
  logic [6:0]      vel;
  logic [6:0]      rem;
  logic [3:0]      oct;
  logic [HP_W-1:0] half;
  logic [HP_W-1:0] phase_cnt;
  logic            tone_reg;
  logic [7:0]      pwm_cnt;
  logic            accept;
  logic            note_off;

  assign accept   = note_valid & note_ready;
  assign note_off = (velocity[6:0] == 7'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, PLAY: if (accept) state_next = note_off ? IDLE : DECODE;
      DECODE:     if (rem < 7'd12) state_next = LOAD;
      LOAD:       state_next = PLAY;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    note_ready = (state == IDLE) || (state == PLAY);
    active     = (state == PLAY);
  end

  // Note decode by repeated subtraction, then the tone divider and free-running PWM counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vel       <= '0;
      rem       <= '0;
      oct       <= '0;
      half      <= '0;
      phase_cnt <= '0;
      tone_reg  <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      case (state)
        IDLE, PLAY: begin
          if (accept) begin
            if (note_off) begin
              tone_reg <= 1'b0;
            end else begin
              vel <= velocity[6:0];
              rem <= note[6:0];
              oct <= '0;
            end
          end else if (state == PLAY) begin
            if (phase_cnt == half - HP_W'(1)) begin
              phase_cnt <= '0;
              tone_reg  <= ~tone_reg;
            end else begin
              phase_cnt <= phase_cnt + HP_W'(1);
            end
          end
        end
        DECODE: begin
          if (rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
          end
        end
        LOAD: begin
          half      <= HP[rem[3:0]] >> oct;
          phase_cnt <= '0;
          tone_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tone_out = enable & tone_reg;
  assign pwm_out  = enable & tone_reg & (pwm_cnt < {vel, 1'b0});

endmodule

// File: tb/tb_midi_tone_synth.sv
// Self-checking bench for midi_tone_synth against a note-to-frequency model built
// from the equal-temperament formula; runs at a reduced clock rate to keep periods short.
module tb_midi_tone_synth;

  localparam int CLK_HZ = 2_000_000;

  logic       clk;
  logic       rstn;
  logic       enable;
  logic       note_valid;
  logic [7:0] note;
  logic [7:0] velocity;
  logic       note_ready;
  logic       active;
  logic       tone_out;
  logic       pwm_out;

  int checks = 0;
  int errors = 0;

  midi_tone_synth #(.CLK_FRE(CLK_HZ), .HP_W(22)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .note_valid(note_valid), .note(note), .velocity(velocity),
    .note_ready(note_ready), .active(active),
    .tone_out(tone_out), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_half(input int n);
    int  m;
    int  hp;
    real f;
    m  = n & 127;
    f  = 8.17580 * $pow(2.0, real'(m % 12) / 12.0);
    hp = $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
    return hp >> (m / 12);
  endfunction

  function automatic int ref_latency(input int n);
    return (n & 127) / 12 + 2;
  endfunction

  // Offers one event, holds it until accepted, returns cycles spent with note_ready low.
  task automatic send_event(input logic [7:0] n, input logic [7:0] v, output int lat);
    int w;
    lat = 0;
    w = 0;
    @(posedge clk); #1;
    note = n; velocity = v; note_valid = 1'b1;
    do begin @(negedge clk); w++; end while (note_ready !== 1'b1 && w < 50);
    @(posedge clk);
    do begin
      @(negedge clk);
      if (note_ready !== 1'b1) lat++;
    end while (note_ready !== 1'b1 && lat < 50);
    note_valid = 1'b0;
  endtask

  task automatic wait_rise(input int limit, output logic seen);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (tone_out !== 1'b1 && c < limit);
    seen = (tone_out === 1'b1);
  endtask

  // From the first PLAY cycle: cycles to the rising edge, high-phase length, PWM highs in first 256 high cycles.
  task automatic measure_tone(input int limit, output int first, output int high, output int pwm_hi);
    first = 0; high = 0; pwm_hi = 0;
    do begin @(negedge clk); first++; end while (tone_out !== 1'b1 && first < limit);
    if (tone_out !== 1'b1) begin first = -1; return; end
    do begin
      high++;
      if (high <= 256 && pwm_out === 1'b1) pwm_hi++;
      @(negedge clk);
    end while (tone_out === 1'b1 && high < limit);
  endtask

  task automatic test_reset();
    int   lat;
    logic seen;
    repeat (3) @(negedge clk);
    checks++; if (note_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", note_ready); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b want 0", active); end
    checks++; if (tone_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_tone: got %b want 0", tone_out); end
    @(negedge clk) rstn = 1'b1;
    send_event(8'd69, 8'd127, lat);
    wait_rise(5000, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL reset_pre_rise: got %b want 1", seen); end
    @(posedge clk); #2 rstn = 1'b0; #1;
    checks++; if (tone_out !== 1'b0) begin errors++; $display("[TB] FAIL midplay_reset_tone: got %b want 0", tone_out); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL midplay_reset_pwm: got %b want 0", pwm_out); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL midplay_reset_active: got %b want 0", active); end
    checks++; if (note_ready !== 1'b1) begin errors++; $display("[TB] FAIL midplay_reset_ready: got %b want 1", note_ready); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_note(input logic [7:0] n, input logic [7:0] v);
    int lat, first, high, pwm_hi;
    send_event(n, v, lat);
    checks++; if (lat !== ref_latency(n)) begin errors++; $display("[TB] FAIL latency n=%0d: got %0d want %0d", n, lat, ref_latency(n)); end
    checks++; if (tone_out !== 1'b0 || active !== 1'b1) begin errors++; $display("[TB] FAIL play_entry n=%0d: tone %b active %b want 0 1", n, tone_out, active); end
    measure_tone(8000, first, high, pwm_hi);
    checks++; if (first !== ref_half(n)) begin errors++; $display("[TB] FAIL first_toggle n=%0d: got %0d want %0d", n, first, ref_half(n)); end
    checks++; if (high !== ref_half(n)) begin errors++; $display("[TB] FAIL high_len n=%0d: got %0d want %0d", n, high, ref_half(n)); end
    checks++; if (pwm_hi !== 2 * int'(v[6:0])) begin errors++; $display("[TB] FAIL pwm_duty n=%0d v=%0d: got %0d want %0d", n, v, pwm_hi, 2 * int'(v[6:0])); end
  endtask

  task automatic test_note_off();
    int   lat, low_cnt, high_cnt;
    logic seen;
    send_event(8'd60, 8'd100, lat);
    wait_rise(8000, seen);
    send_event(8'd60, 8'd0, lat);
    checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL noteoff_latency: got %0d want 0", lat); end
    checks++; if (tone_out !== 1'b0 || active !== 1'b0) begin errors++; $display("[TB] FAIL noteoff_outputs: tone %b active %b want 0 0", tone_out, active); end
    low_cnt = 0; high_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (note_ready !== 1'b1) low_cnt++;
      if (tone_out !== 1'b0) high_cnt++;
    end
    checks++; if (low_cnt !== 0 || high_cnt !== 0) begin errors++; $display("[TB] FAIL noteoff_idle: ready-low %0d tone-high %0d want 0 0", low_cnt, high_cnt); end
  endtask

  task automatic test_retrigger();
    int   lat, cnt, held_bad, first, high, pwm_hi;
    logic seen;
    send_event(8'd69, 8'd127, lat);
    wait_rise(5000, seen);
    @(posedge clk); #1;
    note = 8'd127; velocity = 8'd10; note_valid = 1'b1;
    @(posedge clk);
    cnt = 0; held_bad = 0;
    do begin
      @(negedge clk);
      if (note_ready !== 1'b1) begin
        cnt++;
        if (tone_out !== 1'b1 && cnt <= ref_latency(127) - 1) held_bad++;
      end
    end while (note_ready !== 1'b1 && cnt < 50);
    note_valid = 1'b0;
    checks++; if (cnt !== ref_latency(127)) begin errors++; $display("[TB] FAIL retrig_ready_low: got %0d want %0d", cnt, ref_latency(127)); end
    checks++; if (held_bad !== 0) begin errors++; $display("[TB] FAIL retrig_tone_hold: %0d decode cycles lost the tone, want 0", held_bad); end
    checks++; if (tone_out !== 1'b0) begin errors++; $display("[TB] FAIL retrig_phase_clear: got %b want 0", tone_out); end
    measure_tone(2000, first, high, pwm_hi);
    checks++; if (first !== ref_half(127)) begin errors++; $display("[TB] FAIL retrig_first: got %0d want %0d", first, ref_half(127)); end
    checks++; if (high !== ref_half(127)) begin errors++; $display("[TB] FAIL retrig_high: got %0d want %0d", high, ref_half(127)); end
  endtask

  task automatic test_note0();
    int lat, hi;
    send_event(8'd0, 8'd50, lat);
    checks++; if (lat !== ref_latency(0)) begin errors++; $display("[TB] FAIL note0_latency: got %0d want %0d", lat, ref_latency(0)); end
    hi = 0;
    repeat (300) begin @(negedge clk); if (tone_out !== 1'b0) hi++; end
    checks++; if (hi !== 0 || active !== 1'b1) begin errors++; $display("[TB] FAIL note0_low_phase: high %0d active %b want 0 1", hi, active); end
  endtask

  task automatic test_enable();
    int   lat, k, dis_hi;
    logic seen;
    send_event(8'd69, 8'd127, lat);
    wait_rise(5000, seen);
    k = 1;
    repeat (10) begin @(negedge clk); k++; end
    @(posedge clk); #1 enable = 1'b0; #1;
    checks++; if (tone_out !== 1'b0 || pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL enable_gate: tone %b pwm %b want 0 0", tone_out, pwm_out); end
    dis_hi = 0;
    repeat (20) begin @(negedge clk); k++; if (tone_out !== 1'b0) dis_hi++; end
    checks++; if (dis_hi !== 0 || active !== 1'b1) begin errors++; $display("[TB] FAIL enable_hold: high %0d active %b want 0 1", dis_hi, active); end
    @(posedge clk); #1 enable = 1'b1; #1;
    checks++; if (tone_out !== 1'b1) begin errors++; $display("[TB] FAIL enable_resume: got %b want 1", tone_out); end
    do begin @(negedge clk); if (tone_out === 1'b1) k++; end while (tone_out === 1'b1 && k < 8000);
    checks++; if (k !== ref_half(69)) begin errors++; $display("[TB] FAIL enable_phase: high %0d want %0d", k, ref_half(69)); end
  endtask

  task automatic test_random();
    logic [7:0] n, v;
    for (int i = 0; i < 4; i++) begin
      n = 8'(60 + $urandom_range(0, 35)) | (8'($urandom_range(0, 1)) << 7);
      v = 8'($urandom_range(1, 127)) | (8'($urandom_range(0, 1)) << 7);
      test_note(n, v);
    end
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; note_valid = 1'b0; note = '0; velocity = '0;
    test_reset();
    test_note(8'd69, 8'd127);
    test_note(8'd60, 8'd64);
    test_note_off();
    test_retrigger();
    test_note0();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
